// File: rtl/dragon_pal_sync_gen.sv
// Dragon PAL sync generator: dot/line counters with registered HSn, FSn,
// Active and FieldStart decoded from the next counter values.

module dragon_pal_sync_gen_chk #(
  parameter int H_TOTAL  = 228,
  parameter int HS_START = 200,
  parameter int HS_WIDTH = 16,
  parameter int V_TOTAL  = 312,
  parameter int FS_START = 240,
  parameter int FS_LINES = 32,
  parameter int ACT_H    = 128,
  parameter int ACT_V    = 192
) ();
  if (HS_START + HS_WIDTH > H_TOTAL) begin : g_hs_fit
    $error("dragon_pal_sync_gen: HSn pulse runs past end of line");
  end
  if (FS_START + FS_LINES > V_TOTAL) begin : g_fs_fit
    $error("dragon_pal_sync_gen: FSn pulse runs past end of field");
  end
  if (ACT_H >= HS_START) begin : g_act_h
    $error("dragon_pal_sync_gen: active width overlaps HSn");
  end
  if (ACT_V > FS_START) begin : g_act_v
    $error("dragon_pal_sync_gen: active height overlaps FSn");
  end
  if (H_TOTAL > 256 || H_TOTAL < 2) begin : g_h_range
    $error("dragon_pal_sync_gen: H_TOTAL out of range");
  end
  if (V_TOTAL > 512 || V_TOTAL < 2) begin : g_v_range
    $error("dragon_pal_sync_gen: V_TOTAL out of range");
  end
endmodule

module dragon_pal_sync_gen #(
  parameter int H_TOTAL  = 228,
  parameter int HS_START = 200,
  parameter int HS_WIDTH = 16,
  parameter int V_TOTAL  = 312,
  parameter int FS_START = 240,
  parameter int FS_LINES = 32,
  parameter int ACT_H    = 128,
  parameter int ACT_V    = 192
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ClkEn,
  output logic       HSn,
  output logic       FSn,
  output logic [7:0] DotCount,
  output logic [8:0] LineCount,
  output logic       Active,
  output logic       FieldStart
);

  localparam logic [7:0] H_LAST   = 8'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [9:0] HS_BEG_W = 10'(HS_START);
  localparam logic [9:0] HS_END_W = 10'(HS_START + HS_WIDTH);
  localparam logic [9:0] FS_BEG_W = 10'(FS_START);
  localparam logic [9:0] FS_END_W = 10'(FS_START + FS_LINES);
  localparam logic [9:0] ACT_H_W  = 10'(ACT_H);
  localparam logic [9:0] ACT_V_W  = 10'(ACT_V);

  dragon_pal_sync_gen_chk #(
    .H_TOTAL(H_TOTAL), .HS_START(HS_START), .HS_WIDTH(HS_WIDTH),
    .V_TOTAL(V_TOTAL), .FS_START(FS_START), .FS_LINES(FS_LINES),
    .ACT_H(ACT_H), .ACT_V(ACT_V)
  ) u_chk ();

  logic [7:0] dot_r;
  logic [8:0] line_r;
  logic       hsn_r;
  logic       fsn_r;
  logic       act_r;
  logic       fst_r;

  logic [7:0] dot_nxt_s;
  logic [8:0] line_nxt_s;
  logic [9:0] dot_w_s;
  logic [9:0] line_w_s;
  logic       hsn_nxt_s;
  logic       fsn_nxt_s;
  logic       act_nxt_s;
  logic       fst_nxt_s;

  // Next dot/line position, line advancing only on the dot wrap.
  always_comb begin
    dot_nxt_s  = dot_r;
    line_nxt_s = line_r;
    if (dot_r == H_LAST) begin
      dot_nxt_s = 8'd0;
      if (line_r == V_LAST) begin
        line_nxt_s = 9'd0;
      end else begin
        line_nxt_s = line_r + 9'd1;
      end
    end else begin
      dot_nxt_s = dot_r + 8'd1;
    end
  end

  // Decode strobes from the next position so they line up with the counters.
  always_comb begin
    dot_w_s   = {2'b00, dot_nxt_s};
    line_w_s  = {1'b0, line_nxt_s};
    hsn_nxt_s = ~((dot_w_s >= HS_BEG_W) && (dot_w_s < HS_END_W));
    fsn_nxt_s = ~((line_w_s >= FS_BEG_W) && (line_w_s < FS_END_W));
    act_nxt_s = (dot_w_s < ACT_H_W) && (line_w_s < ACT_V_W);
    fst_nxt_s = (dot_nxt_s == 8'd0) && (line_nxt_s == 9'd0);
  end

  // Counter and output registers; everything holds while ClkEn is low.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dot_r  <= 8'd0;
      line_r <= 9'd0;
      hsn_r  <= 1'b1;
      fsn_r  <= 1'b1;
      act_r  <= 1'b1;
      fst_r  <= 1'b1;
    end else if (ClkEn) begin
      dot_r  <= dot_nxt_s;
      line_r <= line_nxt_s;
      hsn_r  <= hsn_nxt_s;
      fsn_r  <= fsn_nxt_s;
      act_r  <= act_nxt_s;
      fst_r  <= fst_nxt_s;
    end
  end

  assign DotCount   = dot_r;
  assign LineCount  = line_r;
  assign HSn        = hsn_r;
  assign FSn        = fsn_r;
  assign Active     = act_r;
  assign FieldStart = fst_r;

endmodule

// File: tb/tb_dragon_pal_sync_gen.sv
// Bench for dragon_pal_sync_gen: default build plus a small override build,
// both compared against an arithmetic position model (t enabled edges since reset).

module tb_dragon_pal_sync_gen;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic       hsn_a, fsn_a, act_a, fst_a;
  logic [7:0] dot_a;
  logic [8:0] line_a;
  logic       hsn_b, fsn_b, act_b, fst_b;
  logic [7:0] dot_b;
  logic [8:0] line_b;

  dragon_pal_sync_gen dut_a (
    .Clk(Clk), .Reset(rst_a), .ClkEn(en_a), .HSn(hsn_a), .FSn(fsn_a),
    .DotCount(dot_a), .LineCount(line_a), .Active(act_a), .FieldStart(fst_a)
  );

  dragon_pal_sync_gen #(
    .H_TOTAL(10), .HS_START(6), .HS_WIDTH(2), .V_TOTAL(5),
    .FS_START(3), .FS_LINES(1), .ACT_H(4), .ACT_V(2)
  ) dut_b (
    .Clk(Clk), .Reset(rst_b), .ClkEn(en_b), .HSn(hsn_b), .FSn(fsn_b),
    .DotCount(dot_b), .LineCount(line_b), .Active(act_b), .FieldStart(fst_b)
  );

  typedef struct packed {
    logic       hsn;
    logic       fsn;
    logic [7:0] dot;
    logic [8:0] line;
    logic       act;
    logic       fst;
  } vid_t;

  int checks = 0;
  int passes = 0;
  int ta  = 0;
  int tbk = 0;

  function automatic vid_t model(input int t, input int ht, input int hs0, input int hw,
                                 input int vt, input int fs0, input int fl,
                                 input int ah, input int av);
    vid_t v;
    int d, l;
    d = t % ht;
    l = (t / ht) % vt;
    v.hsn  = !(d >= hs0 && d < hs0 + hw);
    v.fsn  = !(l >= fs0 && l < fs0 + fl);
    v.dot  = 8'(d);
    v.line = 9'(l);
    v.act  = (d < ah) && (l < av);
    v.fst  = (d == 0) && (l == 0);
    return v;
  endfunction

  function automatic vid_t exp_a(input int t);
    return model(t, 228, 200, 16, 312, 240, 32, 128, 192);
  endfunction

  function automatic vid_t exp_b(input int t);
    return model(t, 10, 6, 2, 5, 3, 1, 4, 2);
  endfunction

  function automatic vid_t obs_a();
    return {hsn_a, fsn_a, dot_a, line_a, act_a, fst_a};
  endfunction

  function automatic vid_t obs_b();
    return {hsn_b, fsn_b, dot_b, line_b, act_b, fst_b};
  endfunction

  task automatic step_a(input logic en);
    en_a = en;
    @(posedge Clk);
    #1;
    if (en) ta++;
  endtask

  task automatic step_b(input logic en);
    en_b = en;
    @(posedge Clk);
    #1;
    if (en) tbk++;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1;
    #2;
    checks++;
    if (obs_a() !== exp_a(0)) $display("FAIL reset_a: got %h want %h", obs_a(), exp_a(0));
    else passes++;
    checks++;
    if (obs_b() !== exp_b(0)) $display("FAIL reset_b: got %h want %h", obs_b(), exp_b(0));
    else passes++;
    @(posedge Clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    ta = 0; tbk = 0;
  endtask

  task automatic test_full_field();
    int   hs_low_l0, fs_low, fs_first, fst_cnt, fst_at, hs_fall_fs, act_fall;
    logic prev_hsn, prev_act;
    hs_low_l0 = 0; fs_low = 0; fs_first = -1; fst_cnt = 0; fst_at = -1;
    hs_fall_fs = 0; act_fall = -1;
    prev_hsn = hsn_a; prev_act = act_a;
    for (int i = 0; i < 71136; i++) begin
      step_a(1'b1);
      checks++;
      if (obs_a() !== exp_a(ta)) $display("FAIL field_vec t=%0d: got %h want %h", ta, obs_a(), exp_a(ta));
      else passes++;
      if (!hsn_a && line_a == 9'd0) hs_low_l0++;
      if (prev_act && !act_a && act_fall < 0) act_fall = int'(dot_a);
      if (!fsn_a) begin
        fs_low++;
        if (fs_first < 0) fs_first = ta;
        if (prev_hsn && !hsn_a) hs_fall_fs++;
      end
      if (fst_a) begin
        fst_cnt++;
        fst_at = ta;
      end
      if (ta == 228) begin
        checks++;
        if (dot_a !== 8'd0 || line_a !== 9'd1)
          $display("FAIL line_wrap: got dot %0d line %0d want dot 0 line 1", dot_a, line_a);
        else passes++;
      end
      prev_hsn = hsn_a; prev_act = act_a;
    end
    checks++;
    if (hs_low_l0 != 16) $display("FAIL hs_width: got %0d want 16", hs_low_l0); else passes++;
    checks++;
    if (act_fall != 128) $display("FAIL active_fall: got %0d want 128", act_fall); else passes++;
    checks++;
    if (fs_first != 240 * 228) $display("FAIL fs_start: got %0d want %0d", fs_first, 240 * 228); else passes++;
    checks++;
    if (fs_low != 32 * 228) $display("FAIL fs_len: got %0d want %0d", fs_low, 32 * 228); else passes++;
    checks++;
    if (hs_fall_fs != 32) $display("FAIL hs_in_fs: got %0d want 32", hs_fall_fs); else passes++;
    checks++;
    if (fst_cnt != 1 || fst_at != 71136)
      $display("FAIL field_start: got %0d pulses at %0d want 1 at 71136", fst_cnt, fst_at);
    else passes++;
  endtask

  task automatic test_clken_alt();
    int   pos0, pos1, delta, hs_low;
    vid_t prev;
    hs_low = 0;
    pos0 = int'(line_a) * 228 + int'(dot_a);
    for (int i = 0; i < 456; i++) begin
      prev = obs_a();
      step_a(i % 2 == 0);
      if (!hsn_a) hs_low++;
      checks++;
      if (i % 2 == 1) begin
        if (obs_a() !== prev) $display("FAIL clken_hold i=%0d: got %h want %h", i, obs_a(), prev);
        else passes++;
      end else begin
        if (obs_a() !== exp_a(ta)) $display("FAIL clken_vec i=%0d: got %h want %h", i, obs_a(), exp_a(ta));
        else passes++;
      end
    end
    pos1  = int'(line_a) * 228 + int'(dot_a);
    delta = (pos1 - pos0 + 71136) % 71136;
    checks++;
    if (delta != 228) $display("FAIL clken_steps: got %0d want 228", delta); else passes++;
    checks++;
    if (hs_low != 32) $display("FAIL clken_hs_low: got %0d want 32", hs_low); else passes++;
  endtask

  task automatic test_async_reset();
    int first_dot, first_line;
    bit found;
    for (int i = 0; i < 600 && (ta % 71136) != 433; i++) step_a(1'b1);
    checks++;
    if (obs_a() !== exp_a(ta) || hsn_a !== 1'b0)
      $display("FAIL pre_reset: got %h want %h", obs_a(), exp_a(ta));
    else passes++;
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if (obs_a() !== exp_a(0)) $display("FAIL async_reset: got %h want %h", obs_a(), exp_a(0));
    else passes++;
    ta = 0;
    @(posedge Clk);
    #1;
    rst_a = 1'b0;
    found = 1'b0; first_dot = -1; first_line = -1;
    for (int i = 0; i < 300 && !found; i++) begin
      step_a(1'b1);
      checks++;
      if (obs_a() !== exp_a(ta)) $display("FAIL post_reset t=%0d: got %h want %h", ta, obs_a(), exp_a(ta));
      else passes++;
      if (!hsn_a) begin
        found = 1'b1; first_dot = int'(dot_a); first_line = int'(line_a);
      end
    end
    checks++;
    if (!found || first_dot != 200 || first_line != 0)
      $display("FAIL first_hs: got dot %0d line %0d want dot 200 line 0", first_dot, first_line);
    else passes++;
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 1500; i++) begin
      step_a(1'($urandom_range(0, 1)));
      checks++;
      if (obs_a() !== exp_a(ta)) $display("FAIL rand_vec t=%0d: got %h want %h", ta, obs_a(), exp_a(ta));
      else passes++;
    end
  endtask

  task automatic test_small_field();
    int fst_cnt, fs_low0, fs_first, hs_low;
    fst_cnt = 0; fs_low0 = 0; fs_first = -1; hs_low = 0;
    for (int i = 0; i < 150; i++) begin
      step_b(1'b1);
      checks++;
      if (obs_b() !== exp_b(tbk)) $display("FAIL small_vec t=%0d: got %h want %h", tbk, obs_b(), exp_b(tbk));
      else passes++;
      if (fst_b) begin
        fst_cnt++;
        checks++;
        if (tbk % 50 != 0) $display("FAIL small_period: got pulse at %0d want multiple of 50", tbk);
        else passes++;
      end
      if (!fsn_b && tbk < 50) begin
        fs_low0++;
        if (fs_first < 0) fs_first = tbk;
      end
      if (!hsn_b) hs_low++;
    end
    checks++;
    if (fst_cnt != 3) $display("FAIL small_fst_cnt: got %0d want 3", fst_cnt); else passes++;
    checks++;
    if (fs_first != 30 || fs_low0 != 10)
      $display("FAIL small_fs: got start %0d len %0d want start 30 len 10", fs_first, fs_low0);
    else passes++;
    checks++;
    if (hs_low != 30) $display("FAIL small_hs: got %0d want 30", hs_low); else passes++;
  endtask

  task automatic test_small_async_reset();
    for (int i = 0; i < 37; i++) step_b(1'b1);
    checks++;
    if (obs_b() !== exp_b(tbk) || hsn_b !== 1'b0 || fsn_b !== 1'b0)
      $display("FAIL small_pre_reset: got %h want %h", obs_b(), exp_b(tbk));
    else passes++;
    #2;
    rst_b = 1'b1;
    #1;
    checks++;
    if (obs_b() !== exp_b(0)) $display("FAIL small_async_reset: got %h want %h", obs_b(), exp_b(0));
    else passes++;
    tbk = 0;
    @(posedge Clk);
    #1;
    rst_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step_b(1'b1);
      checks++;
      if (obs_b() !== exp_b(tbk)) $display("FAIL small_post t=%0d: got %h want %h", tbk, obs_b(), exp_b(tbk));
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_full_field();
    test_clken_alt();
    test_async_reset();
    test_random_en();
    en_a = 1'b0;
    test_small_field();
    test_small_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
